// File: rtl/mac_checker_pkg.sv
// Shared codes, FSM state type, CRC constants and header offsets for the
// MAC receive-stream checker.
package mac_checker_pkg;

    localparam logic [7:0] C_START    = 8'hFB;
    localparam logic [7:0] C_TERM     = 8'hFD;
    localparam logic [7:0] C_IDLE     = 8'h07;
    localparam logic [7:0] C_ERROR    = 8'hFE;
    localparam logic [7:0] D_PREAMBLE = 8'h55;
    localparam logic [7:0] D_SFD      = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_FRAME,
        ST_DONE
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned OFS_DA = 0;
    localparam int unsigned OFS_SA = 6;
    localparam int unsigned OFS_LT = 12;

    typedef struct packed {
        logic pre;
        logic hdr;
        logic len;
        logic size;
        logic fcs;
        logic framing;
    } status_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int unsigned b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Byte i of a 48-bit address in wire order (MSB byte first); i must be < 6.
    function automatic logic [7:0] addr_byte(input logic [47:0] a, input int unsigned i);
        logic [47:0] s;
        s = a << (8 * i);
        return s[47:40];
    endfunction

endpackage

// File: rtl/crc32_lanes.sv
// Combinational reflected CRC-32 update over the enabled byte lanes of one beat,
// applied in lane order (lane 0 first).
module crc32_lanes
    import mac_checker_pkg::*;
#(
    parameter int unsigned LANES = 8
) (
    input  logic [31:0]        i_crc,
    input  logic [8*LANES-1:0] i_data,
    input  logic [LANES-1:0]   i_en,
    output logic [31:0]        o_crc
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (i_en[k]) begin
                w_crc = crc32_byte(w_crc, i_data[8*k +: 8]);
            end
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/mac_stream_checker.sv
// Checks a lane-oriented MAC receive stream frame by frame: preamble, header,
// length, size, FCS and framing, plus saturating frame/error statistics.
module mac_stream_checker
    import mac_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned MIN_FRAME_SIZE = 64,
    parameter int unsigned MAX_FRAME_SIZE = 1518,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter logic [47:0] DST_ADDR_CODE  = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_ADDR_CODE  = 48'h123456789ABC
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    input  logic                  i_valid,
    output logic                  o_frame_done,
    output logic                  o_preamble_error,
    output logic                  o_header_error,
    output logic                  o_length_error,
    output logic                  o_size_error,
    output logic                  o_fcs_error,
    output logic                  o_framing_error,
    output logic [10:0]           o_payload_bytes,
    output logic [CNT_WIDTH-1:0]  o_frame_count,
    output logic [CNT_WIDTH-1:0]  o_error_count
);

    localparam int unsigned    LANES   = DATA_WIDTH / 8;
    localparam logic [15:0]    CNT_SAT = 16'(MAX_FRAME_SIZE + 1);
    localparam logic [15:0]    MIN_B   = 16'(MIN_FRAME_SIZE);
    localparam logic [15:0]    MAX_B   = 16'(MAX_FRAME_SIZE);

    state_t                r_state;
    logic [2:0]            r_pre_idx;
    logic [15:0]           r_byte_cnt;
    logic [15:0]           r_lt;
    logic                  r_pre_err, r_hdr_err, r_frm_err;
    logic [31:0]           r_crc;
    logic                  r_frame_done;
    status_t               r_status;
    logic [10:0]           r_payload;
    logic [CNT_WIDTH-1:0]  r_frame_count, r_error_count;

    logic                  w_start0, w_active, w_restart, w_scan, w_term, w_done;
    state_t                w_ph;
    logic [2:0]            w_pre_idx;
    logic [15:0]           w_cnt, w_lt;
    logic                  w_pre_err, w_hdr_err, w_frm_err;
    logic [LANES-1:0]      w_en;
    logic [7:0]            w_byte;
    logic                  w_ctl;
    int unsigned           w_idx;
    logic [31:0]           w_crc_in, w_crc_next;
    logic [15:0]           f_cnt, f_lt, w_pay, w_min_pay;
    logic [31:0]           f_crc;
    status_t               w_status;

    assign w_start0  = i_valid && i_rx_ctrl[0] && (i_rx_data[7:0] == C_START);
    assign w_active  = (r_state == ST_PREAMBLE) || (r_state == ST_FRAME);
    assign w_restart = w_start0 && w_active;
    assign w_scan    = w_start0 || (i_valid && w_active);
    assign w_crc_in  = w_start0 ? CRC_INIT : r_crc;

    // Lane-serial scan of one beat; a START in lane 0 restarts the scan state.
    always_comb begin
        w_ph      = r_state;
        w_pre_idx = r_pre_idx;
        w_cnt     = r_byte_cnt;
        w_lt      = r_lt;
        w_pre_err = r_pre_err;
        w_hdr_err = r_hdr_err;
        w_frm_err = r_frm_err;
        w_en      = '0;
        w_byte    = '0;
        w_ctl     = 1'b0;
        w_idx     = 0;
        if (w_start0) begin
            w_ph      = ST_PREAMBLE;
            w_pre_idx = '0;
            w_cnt     = '0;
            w_lt      = '0;
            w_pre_err = 1'b0;
            w_hdr_err = 1'b0;
            w_frm_err = 1'b0;
        end else if (!w_scan) begin
            w_ph = ST_IDLE;
        end
        for (int unsigned k = 0; k < LANES; k++) begin
            w_byte = i_rx_data[8*k +: 8];
            w_ctl  = i_rx_ctrl[k];
            w_idx  = 32'(w_cnt);
            if (w_start0 && k == 0) begin
                w_pre_idx = w_pre_idx;
            end else if (w_ph == ST_PREAMBLE) begin
                if (w_ctl && w_byte == C_TERM) begin
                    w_pre_err = 1'b1;
                    w_ph      = ST_DONE;
                end else begin
                    if (w_ctl || w_byte != ((w_pre_idx == 3'd6) ? D_SFD : D_PREAMBLE)) begin
                        w_pre_err = 1'b1;
                    end
                    if (w_pre_idx == 3'd6) begin
                        w_ph = ST_FRAME;
                    end
                    w_pre_idx = w_pre_idx + 3'd1;
                end
            end else if (w_ph == ST_FRAME) begin
                if (w_ctl) begin
                    if (w_byte == C_TERM) begin
                        w_ph = ST_DONE;
                    end else begin
                        w_frm_err = 1'b1;
                    end
                end else begin
                    w_en[k] = 1'b1;
                    if (w_idx < OFS_SA && w_byte != addr_byte(DST_ADDR_CODE, w_idx - OFS_DA)) begin
                        w_hdr_err = 1'b1;
                    end
                    if (w_idx >= OFS_SA && w_idx < OFS_LT &&
                        w_byte != addr_byte(SRC_ADDR_CODE, w_idx - OFS_SA)) begin
                        w_hdr_err = 1'b1;
                    end
                    if (w_idx == OFS_LT) begin
                        w_lt[15:8] = w_byte;
                    end
                    if (w_idx == OFS_LT + 1) begin
                        w_lt[7:0] = w_byte;
                    end
                    if (w_cnt != CNT_SAT) begin
                        w_cnt = w_cnt + 16'd1;
                    end
                end
            end
        end
    end

    crc32_lanes #(.LANES(LANES)) u_crc (
        .i_crc  (w_crc_in),
        .i_data (i_rx_data),
        .i_en   (w_en),
        .o_crc  (w_crc_next)
    );

    // A restart closes the previous frame from its registered state, not this beat.
    always_comb begin
        w_term = i_valid && !w_restart && (w_ph == ST_DONE);
        w_done = w_restart || w_term;
        f_cnt  = w_restart ? r_byte_cnt : w_cnt;
        f_lt   = w_restart ? r_lt       : w_lt;
        f_crc  = w_restart ? r_crc      : w_crc_next;
        w_status.pre     = w_restart ? r_pre_err : w_pre_err;
        w_status.framing = w_restart ? 1'b1      : w_frm_err;
        w_status.hdr     = (w_restart ? r_hdr_err : w_hdr_err) ||
                           (f_lt >= 16'd1501 && f_lt <= 16'd1535);
        w_pay            = (f_cnt >= 16'd18) ? (f_cnt - 16'd18) : 16'd0;
        w_min_pay        = (f_lt < 16'd46) ? 16'd46 : f_lt;
        w_status.len     = (f_lt <= 16'd1500) && (w_pay != w_min_pay);
        w_status.size    = (f_cnt < MIN_B) || (f_cnt > MAX_B);
        w_status.fcs     = (f_crc != CRC_RESIDUE);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_pre_idx     <= '0;
            r_byte_cnt    <= '0;
            r_lt          <= '0;
            r_pre_err     <= 1'b0;
            r_hdr_err     <= 1'b0;
            r_frm_err     <= 1'b0;
            r_crc         <= CRC_INIT;
            r_frame_done  <= 1'b0;
            r_status      <= '0;
            r_payload     <= '0;
            r_frame_count <= '0;
            r_error_count <= '0;
        end else begin
            r_frame_done <= w_done;
            if (w_done) begin
                r_status  <= w_status;
                r_payload <= w_pay[10:0];
                if (r_frame_count != '1) begin
                    r_frame_count <= r_frame_count + CNT_WIDTH'(1);
                end
                if (w_status != '0 && r_error_count != '1) begin
                    r_error_count <= r_error_count + CNT_WIDTH'(1);
                end
            end
            if (w_scan) begin
                r_state    <= w_ph;
                r_pre_idx  <= w_pre_idx;
                r_byte_cnt <= w_cnt;
                r_lt       <= w_lt;
                r_pre_err  <= w_pre_err;
                r_hdr_err  <= w_hdr_err;
                r_frm_err  <= w_frm_err;
                r_crc      <= w_crc_next;
            end else if (r_state == ST_DONE) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign o_frame_done     = r_frame_done;
    assign o_preamble_error = r_status.pre;
    assign o_header_error   = r_status.hdr;
    assign o_length_error   = r_status.len;
    assign o_size_error     = r_status.size;
    assign o_fcs_error      = r_status.fcs;
    assign o_framing_error  = r_status.framing;
    assign o_payload_bytes  = r_payload;
    assign o_frame_count    = r_frame_count;
    assign o_error_count    = r_error_count;

endmodule

// File: tb/tb_mac_stream_checker.sv
// Directed-vector bench for mac_stream_checker: a 64-bit and a 32-bit instance
// fed hand-built frames, each finished frame compared against hand-derived status.
module tb_mac_stream_checker;

    localparam logic [5:0] F_PRE  = 6'b100000;
    localparam logic [5:0] F_HDR  = 6'b010000;
    localparam logic [5:0] F_LEN  = 6'b001000;
    localparam logic [5:0] F_SIZE = 6'b000100;
    localparam logic [5:0] F_FCS  = 6'b000010;
    localparam logic [5:0] F_FRM  = 6'b000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst64, v64, done64, pre64, hdr64, len64, size64, fcs64, frm64;
    logic [63:0] d64;
    logic [7:0]  c64;
    logic [10:0] pay64;
    logic [31:0] fc64, ec64;

    logic        rst32, v32, done32, pre32, hdr32, len32, size32, fcs32, frm32;
    logic [31:0] d32;
    logic [3:0]  c32;
    logic [10:0] pay32;
    logic [31:0] fc32, ec32;

    mac_stream_checker #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .i_rst(rst64), .i_rx_data(d64), .i_rx_ctrl(c64), .i_valid(v64),
        .o_frame_done(done64), .o_preamble_error(pre64), .o_header_error(hdr64),
        .o_length_error(len64), .o_size_error(size64), .o_fcs_error(fcs64),
        .o_framing_error(frm64), .o_payload_bytes(pay64),
        .o_frame_count(fc64), .o_error_count(ec64)
    );

    mac_stream_checker #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut32 (
        .clk(clk), .i_rst(rst32), .i_rx_data(d32), .i_rx_ctrl(c32), .i_valid(v32),
        .o_frame_done(done32), .o_preamble_error(pre32), .o_header_error(hdr32),
        .o_length_error(len32), .o_size_error(size32), .o_fcs_error(fcs32),
        .o_framing_error(frm32), .o_payload_bytes(pay32),
        .o_frame_count(fc32), .o_error_count(ec32)
    );

    typedef struct packed {
        logic [5:0]  flags;
        logic [10:0] pay;
        logic [31:0] fc;
        logic [31:0] ec;
        logic [31:0] cyc;
    } rec_t;

    rec_t        q64[$];
    rec_t        q32[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned term_cyc = 0;
    logic [7:0]  tx_b [0:255];
    logic        tx_c [0:255];
    int unsigned tx_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rec_t r;
        if (done64) begin
            r = {pre64, hdr64, len64, size64, fcs64, frm64, pay64, fc64, ec64, cyc};
            q64.push_back(r);
        end
        if (done32) begin
            r = {pre32, hdr32, len32, size32, fcs32, frm32, pay32, fc32, ec32, cyc};
            q32.push_back(r);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC, one data bit at a time, LSB first.
    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic put(input logic [7:0] b, input logic c);
        tx_b[tx_len] = b;
        tx_c[tx_len] = c;
        tx_len++;
    endtask

    task automatic build(input logic [15:0] lt, input int plen, input bit flip,
                         input logic [7:0] pre3, input logic [7:0] sa5);
        logic [31:0] crc;
        logic [47:0] sa;
        sa = {40'h123456789A, sa5};
        tx_len = 0;
        put(8'hFB, 1'b1);
        for (int i = 1; i <= 6; i++) put((i == 3) ? pre3 : 8'h55, 1'b0);
        put(8'hD5, 1'b0);
        for (int i = 0; i < 6; i++) put(8'hFF, 1'b0);
        for (int i = 5; i >= 0; i--) put(sa[8*i +: 8], 1'b0);
        put(lt[15:8], 1'b0);
        put(lt[7:0], 1'b0);
        for (int i = 0; i < plen; i++) put(8'(i * 7 + 3), 1'b0);
        crc = 32'hFFFFFFFF;
        for (int unsigned i = 8; i < tx_len; i++) crc = ref_crc(crc, tx_b[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) put(crc[8*i +: 8], 1'b0);
        if (flip) tx_b[8 + 14 + 5] = tx_b[8 + 14 + 5] ^ 8'h01;
        put(8'hFD, 1'b1);
    endtask

    task automatic drive(input int lanes, input logic [63:0] d, input logic [7:0] c, input logic v);
        if (lanes == 8) begin
            d64 = d; c64 = c; v64 = v;
        end else begin
            d32 = d[31:0]; c32 = c[3:0]; v32 = v;
        end
    endtask

    task automatic send(input int lanes, input int max_beats, input int gap_at);
        int          nb;
        int unsigned idx;
        logic [63:0] d;
        logic [7:0]  c;
        bit          has_term;
        nb = (int'(tx_len) + lanes - 1) / lanes;
        if (max_beats < nb) nb = max_beats;
        for (int b = 0; b < nb; b++) begin
            if (gap_at == b) begin
                @(posedge clk); #1;
                drive(lanes, {8{8'hFB}}, 8'hFF, 1'b0);
            end
            d = '0; c = '0; has_term = 1'b0;
            for (int k = 0; k < lanes; k++) begin
                idx = 32'(b * lanes + k);
                if (idx < tx_len) begin
                    d[8*k +: 8] = tx_b[idx];
                    c[k] = tx_c[idx];
                    if (idx == tx_len - 1) has_term = 1'b1;
                end else begin
                    d[8*k +: 8] = 8'h07;
                    c[k] = 1'b1;
                end
            end
            @(posedge clk); #1;
            drive(lanes, d, c, 1'b1);
            if (has_term) term_cyc = cyc + 1;
        end
        @(posedge clk); #1;
        drive(lanes, '0, '0, 1'b0);
    endtask

    function automatic int qsize(input int lanes);
        return (lanes == 8) ? q64.size() : q32.size();
    endfunction

    task automatic check_frame(input string tag, input int lanes, input logic [5:0] ef,
                               input int ep, input int efc, input int eec, input bit lat);
        rec_t r;
        int   n = 0;
        while (qsize(lanes) == 0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, " done"}, 64'(qsize(lanes) != 0), 64'd1);
        if (qsize(lanes) != 0) begin
            r = (lanes == 8) ? q64.pop_front() : q32.pop_front();
            chk({tag, " flags"},   64'(r.flags), 64'(ef));
            chk({tag, " payload"}, 64'(r.pay),   64'(ep));
            chk({tag, " frames"},  64'(r.fc),    64'(efc));
            chk({tag, " errors"},  64'(r.ec),    64'(eec));
            if (lat) chk({tag, " latency"}, 64'(r.cyc), 64'(term_cyc));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst64 = 1'b1; rst32 = 1'b1;
        drive(8, '0, '0, 1'b0);
        drive(4, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst64 = 1'b0; rst32 = 1'b0;
        @(negedge clk);
        chk("rst done",   64'(done64), 64'd0);
        chk("rst flags",  64'({pre64, hdr64, len64, size64, fcs64, frm64}), 64'd0);
        chk("rst payload", 64'(pay64), 64'd0);
        chk("rst frames", 64'(fc64), 64'd0);
        chk("rst errors", 64'(ec64), 64'd0);

        build(16'h002E, 46, 1'b0, 8'h55, 8'hBC);
        send(8, 999, 3);
        check_frame("clean64", 8, 6'b0, 46, 1, 0, 1'b1);

        build(16'h002E, 46, 1'b1, 8'h55, 8'hBC);
        send(8, 999, -1);
        check_frame("bitflip", 8, F_FCS, 46, 2, 1, 1'b1);

        build(16'h0010, 46, 1'b0, 8'h55, 8'hBC);
        send(8, 999, -1);
        check_frame("lt16pad", 8, 6'b0, 46, 3, 1, 1'b1);

        build(16'h0030, 46, 1'b0, 8'h55, 8'hBC);
        send(8, 999, -1);
        check_frame("lt48", 8, F_LEN, 46, 4, 2, 1'b1);

        build(16'h002E, 46, 1'b0, 8'h54, 8'hBD);
        send(8, 999, -1);
        check_frame("pre_sa", 8, F_PRE | F_HDR, 46, 5, 3, 1'b1);

        @(posedge clk); #1; rst64 = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst64 = 1'b0;
        @(negedge clk);
        chk("rst64 frames", 64'(fc64), 64'd0);

        // Frame A truncated after 32 frame bytes by a new START in beat 5.
        build(16'h002E, 46, 1'b0, 8'h55, 8'hBC);
        send(8, 5, -1);
        build(16'h002E, 46, 1'b0, 8'h55, 8'hBC);
        send(8, 999, -1);
        check_frame("restartA", 8, F_FRM | F_LEN | F_SIZE | F_FCS, 14, 1, 1, 1'b0);
        check_frame("restartB", 8, 6'b0, 46, 2, 1, 1'b1);

        build(16'h002E, 46, 1'b0, 8'h55, 8'hBC);
        send(4, 999, -1);
        check_frame("clean32", 4, 6'b0, 46, 1, 0, 1'b1);

        build(16'h002E, 46, 1'b0, 8'h55, 8'hBC);
        send(4, 6, -1);
        @(posedge clk); #1; rst32 = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst32 = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst32 nopulse", 64'(q32.size()), 64'd0);
        chk("rst32 frames",  64'(fc32), 64'd0);
        chk("rst32 errors",  64'(ec32), 64'd0);

        for (int x = 0; x < 4; x++) begin
            build(16'(46 + x), 46 + x, 1'b0, 8'h55, 8'hBC);
            send(4, 999, -1);
            check_frame($sformatf("term_lane%0d", x), 4, 6'b0, 46 + x, x + 1, 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
